// File: rtl/ebu_arbiter_if.sv
// ebu_arbiter_if
// Groups the request/grant handshake and AHB-side beat signals of the
// external bus unit arbiter so they travel as one bundle.
//
// Signals
//   IFUReq, LSUReq      : bus requests from the instruction fetch and load/store units
//   IFUBurst, LSUBurst  : burst length codes (0 = single, 1 = 4, 2 = 8, 3 = 16 beats)
//   HREADY              : AHB beat-accepted strobe
//   IFUGrant, LSUGrant  : current bus owner (never both)
//   HTRANS              : AHB transfer type (00 IDLE, 10 NONSEQ, 11 SEQ)
//   BeatsLeft           : beats remaining after the current beat
//   IFUDone, LSUDone    : one-cycle pulse after the owner's last beat is accepted
//
// Modports
//   master : the arbiter side (drives grants, HTRANS, BeatsLeft, Done)
//   slave  : the requesting/bus environment side
interface ebu_arbiter_if;
    logic       IFUReq;
    logic       LSUReq;
    logic [1:0] IFUBurst;
    logic [1:0] LSUBurst;
    logic       HREADY;
    logic       IFUGrant;
    logic       LSUGrant;
    logic [1:0] HTRANS;
    logic [3:0] BeatsLeft;
    logic       IFUDone;
    logic       LSUDone;

    modport master (
        input  IFUReq, LSUReq, IFUBurst, LSUBurst, HREADY,
        output IFUGrant, LSUGrant, HTRANS, BeatsLeft, IFUDone, LSUDone
    );

    modport slave (
        output IFUReq, LSUReq, IFUBurst, LSUBurst, HREADY,
        input  IFUGrant, LSUGrant, HTRANS, BeatsLeft, IFUDone, LSUDone
    );
endinterface

// File: rtl/ebu_arbiter.sv
// ebu_arbiter
// Two-master bus arbiter for the external bus unit. The LSU has fixed
// priority over the IFU. A granted burst always runs to completion; wait
// states (HREADY low) freeze every output. When the last beat is accepted
// the owner's Done pulses and arbitration happens on that same edge, so a
// pending request is granted back-to-back with a NONSEQ beat.
//
// Optional feature: define EBU_STARVE_GUARD_EN to enable the starvation
// guard. A 4-bit StarveCnt counts LSU grants made while the IFU is waiting
// and, once it reaches STARVE_LIMIT, the IFU wins the next arbitration.
// Without the macro arbitration is strict LSU priority and STARVE_LIMIT
// has no effect.
//
// Ports
//   HCLK     : clock
//   HRESETn  : asynchronous active-low reset
//   bus      : ebu_arbiter_if.master (requests, bursts, HREADY in;
//              grants, HTRANS, BeatsLeft, Done pulses out)
//
// Parameters
//   STARVE_LIMIT : consecutive LSU grants tolerated while the IFU waits (1-15)
module ebu_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    ebu_arbiter_if.master bus
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_L = 2'd2
    } state_t;

    state_t     state;
    logic       ifu_grant_q;
    logic       lsu_grant_q;
    logic [1:0] htrans_q;
    logic [3:0] beats_left_q;
    logic       ifu_done_q;
    logic       lsu_done_q;

    logic       lsu_wins;
    logic       any_req;
    logic [1:0] win_burst;
    logic [3:0] win_beats;

    // Out-of-range limits leave this marker block in the elaborated design.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_starve_limit_out_of_range
    end

`ifdef EBU_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt;

    // The LSU normally wins, but yields once the waiting IFU has been
    // passed over LIMIT times in a row.
    assign lsu_wins = bus.LSUReq && !(bus.IFUReq && (starve_cnt == LIMIT));
`else
    // Strict LSU priority.
    assign lsu_wins = bus.LSUReq;
`endif

    assign any_req = bus.IFUReq || bus.LSUReq;

    // Winner's burst code and the BeatsLeft value loaded at grant.
    always_comb begin
        win_burst = lsu_wins ? bus.LSUBurst : bus.IFUBurst;
        win_beats = 4'd0;
        case (win_burst)
            2'd0:    win_beats = 4'd0;
            2'd1:    win_beats = 4'd3;
            2'd2:    win_beats = 4'd7;
            default: win_beats = 4'd15;
        endcase
    end

    // Main FSM. Every output is a register updated here. Nothing moves
    // while an owned beat waits on HREADY except the Done pulses, which
    // only ever last one cycle. The IDLE state and the final accepted beat
    // share the same arbitration path so back-to-back grants need no gap.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state        <= IDLE;
            ifu_grant_q  <= 1'b0;
            lsu_grant_q  <= 1'b0;
            htrans_q     <= HTRANS_IDLE;
            beats_left_q <= 4'd0;
            ifu_done_q   <= 1'b0;
            lsu_done_q   <= 1'b0;
        end else begin
            ifu_done_q <= 1'b0;
            lsu_done_q <= 1'b0;
            if (state == IDLE || bus.HREADY) begin
                if (state != IDLE && beats_left_q != 4'd0) begin
                    beats_left_q <= beats_left_q - 4'd1;
                    htrans_q     <= HTRANS_SEQ;
                end else begin
                    ifu_done_q <= (state == OWN_I);
                    lsu_done_q <= (state == OWN_L);
                    if (any_req) begin
                        state        <= lsu_wins ? OWN_L : OWN_I;
                        lsu_grant_q  <= lsu_wins;
                        ifu_grant_q  <= !lsu_wins;
                        htrans_q     <= HTRANS_NONSEQ;
                        beats_left_q <= win_beats;
                    end else begin
                        state        <= IDLE;
                        lsu_grant_q  <= 1'b0;
                        ifu_grant_q  <= 1'b0;
                        htrans_q     <= HTRANS_IDLE;
                        beats_left_q <= 4'd0;
                    end
                end
            end
        end
    end

`ifdef EBU_STARVE_GUARD_EN
    // Starvation counter: bumps on every LSU grant made while the IFU is
    // still asking, clears whenever the IFU is granted. Saturates so a
    // long run with the IFU idle-then-requesting can never wrap.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            starve_cnt <= 4'd0;
        end else if ((state == IDLE || (bus.HREADY && beats_left_q == 4'd0)) && any_req) begin
            if (!lsu_wins) begin
                starve_cnt <= 4'd0;
            end else if (bus.IFUReq && starve_cnt != 4'hF) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
`endif

    assign bus.IFUGrant  = ifu_grant_q;
    assign bus.LSUGrant  = lsu_grant_q;
    assign bus.HTRANS    = htrans_q;
    assign bus.BeatsLeft = beats_left_q;
    assign bus.IFUDone   = ifu_done_q;
    assign bus.LSUDone   = lsu_done_q;

endmodule

// File: tb/tb_ebu_arbiter.sv
// tb_ebu_arbiter
// Directed self-checking bench for ebu_arbiter. Inputs change 1 time unit
// after each rising edge and outputs are checked at that same point.
// Expected output words are {IFUGrant, LSUGrant, HTRANS, BeatsLeft,
// IFUDone, LSUDone}, hand-computed per step.
module tb_ebu_arbiter;

    logic HCLK;
    logic HRESETn;
    int   compareCount;
    int   mismatchCount;

    ebu_arbiter_if bus ();

    ebu_arbiter #(.STARVE_LIMIT(4)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus.master)
    );

    // Free-running 10-unit clock.
    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // Drive all request-side inputs at once.
    task automatic applyStimulus(input logic ireq, input logic lreq,
                                 input logic [1:0] ib, input logic [1:0] lb,
                                 input logic hr);
        bus.IFUReq   = ireq;
        bus.LSUReq   = lreq;
        bus.IFUBurst = ib;
        bus.LSUBurst = lb;
        bus.HREADY   = hr;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    function automatic logic [9:0] pack(input logic ig, input logic lg,
                                        input logic [1:0] ht, input logic [3:0] bl,
                                        input logic id, input logic ld);
        return {ig, lg, ht, bl, id, ld};
    endfunction

    // Compare the full output word against the expected one.
    task automatic checkOutput(input string tag, input logic [9:0] expected);
        logic [9:0] observed;
        observed = {bus.IFUGrant, bus.LSUGrant, bus.HTRANS, bus.BeatsLeft,
                    bus.IFUDone, bus.LSUDone};
        compareCount++;
        assert (observed === expected) else begin
            mismatchCount++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Linear directed sequence.
    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        HRESETn = 1'b0;
        applyStimulus(1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
        tick();
        tick();
        checkOutput("reset_state", pack(0, 0, 2'b00, 4'd0, 0, 0));
        HRESETn = 1'b1;
        tick();
        checkOutput("idle_no_req", pack(0, 0, 2'b00, 4'd0, 0, 0));

        $display("[TB] single-beat LSU grant");
        applyStimulus(1'b0, 1'b1, 2'd0, 2'd0, 1'b1);
        tick();
        checkOutput("single_grant", pack(0, 1, 2'b10, 4'd0, 0, 0));
        applyStimulus(1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
        tick();
        checkOutput("single_done", pack(0, 0, 2'b00, 4'd0, 0, 1));
        tick();
        checkOutput("single_idle", pack(0, 0, 2'b00, 4'd0, 0, 0));

        $display("[TB] IFU 4-beat burst with wait states");
        applyStimulus(1'b1, 1'b0, 2'd1, 2'd0, 1'b1);
        tick();
        checkOutput("burst_beat1", pack(1, 0, 2'b10, 4'd3, 0, 0));
        applyStimulus(1'b0, 1'b0, 2'd3, 2'd0, 1'b1);
        tick();
        checkOutput("burst_beat2", pack(1, 0, 2'b11, 4'd2, 0, 0));
        bus.HREADY = 1'b0;
        tick();
        checkOutput("burst_wait1", pack(1, 0, 2'b11, 4'd2, 0, 0));
        tick();
        checkOutput("burst_wait2", pack(1, 0, 2'b11, 4'd2, 0, 0));
        tick();
        checkOutput("burst_wait3", pack(1, 0, 2'b11, 4'd2, 0, 0));
        bus.HREADY = 1'b1;
        tick();
        checkOutput("burst_beat3", pack(1, 0, 2'b11, 4'd1, 0, 0));
        tick();
        checkOutput("burst_beat4", pack(1, 0, 2'b11, 4'd0, 0, 0));
        tick();
        checkOutput("burst_done", pack(0, 0, 2'b00, 4'd0, 1, 0));
        tick();
        checkOutput("burst_idle", pack(0, 0, 2'b00, 4'd0, 0, 0));

        $display("[TB] simultaneous requests");
        applyStimulus(1'b1, 1'b1, 2'd0, 2'd0, 1'b1);
        tick();
        checkOutput("simul_lsu_first", pack(0, 1, 2'b10, 4'd0, 0, 0));
        applyStimulus(1'b1, 1'b0, 2'd0, 2'd0, 1'b1);
        tick();
        checkOutput("simul_ifu_b2b", pack(1, 0, 2'b10, 4'd0, 0, 1));
        applyStimulus(1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
        tick();
        checkOutput("simul_ifu_done", pack(0, 0, 2'b00, 4'd0, 1, 0));
        tick();
        checkOutput("simul_idle", pack(0, 0, 2'b00, 4'd0, 0, 0));

        $display("[TB] starvation run, both requests held");
        applyStimulus(1'b1, 1'b1, 2'd0, 2'd0, 1'b1);
        tick();
        checkOutput("starve_l1", pack(0, 1, 2'b10, 4'd0, 0, 0));
        tick();
        checkOutput("starve_l2", pack(0, 1, 2'b10, 4'd0, 0, 1));
        tick();
        checkOutput("starve_l3", pack(0, 1, 2'b10, 4'd0, 0, 1));
        tick();
        checkOutput("starve_l4", pack(0, 1, 2'b10, 4'd0, 0, 1));
        tick();
`ifdef EBU_STARVE_GUARD_EN
        checkOutput("starve_ifu", pack(1, 0, 2'b10, 4'd0, 0, 1));
        tick();
        checkOutput("starve_lsu_again", pack(0, 1, 2'b10, 4'd0, 1, 0));
`else
        checkOutput("strict_l5", pack(0, 1, 2'b10, 4'd0, 0, 1));
        tick();
        checkOutput("strict_l6", pack(0, 1, 2'b10, 4'd0, 0, 1));
`endif
        applyStimulus(1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
        tick();
        checkOutput("starve_end_done", pack(0, 0, 2'b00, 4'd0, 0, 1));
        tick();
        checkOutput("starve_end_idle", pack(0, 0, 2'b00, 4'd0, 0, 0));

        $display("[TB] reset during LSU 8-beat burst");
        applyStimulus(1'b0, 1'b1, 2'd0, 2'd2, 1'b1);
        tick();
        checkOutput("rst_burst_beat1", pack(0, 1, 2'b10, 4'd7, 0, 0));
        applyStimulus(1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
        tick();
        checkOutput("rst_burst_beat2", pack(0, 1, 2'b11, 4'd6, 0, 0));
        tick();
        tick();
        tick();
        checkOutput("rst_burst_beat5", pack(0, 1, 2'b11, 4'd3, 0, 0));
        #2;
        HRESETn = 1'b0;
        #1;
        checkOutput("rst_async_clear", pack(0, 0, 2'b00, 4'd0, 0, 0));
        tick();
        checkOutput("rst_held_no_done", pack(0, 0, 2'b00, 4'd0, 0, 0));
        HRESETn = 1'b1;
        applyStimulus(1'b0, 1'b1, 2'd0, 2'd2, 1'b1);
        tick();
        checkOutput("rst_regrant", pack(0, 1, 2'b10, 4'd7, 0, 0));
        applyStimulus(1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
        tick();
        checkOutput("rst_regrant_beat2", pack(0, 1, 2'b11, 4'd6, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
